// File: rtl/jk_bank_arbiter_if.sv
// rtl/jk_bank_arbiter_if.sv - request/status bundle for jk_bank_arbiter
// q_par is present only when JKB_PARITY_EN is defined.
interface jk_bank_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_mask;
  logic             req0_ready;
  logic             req1_valid;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_mask;
  logic             req1_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             busy;
  logic             grant;
  logic             done;
`ifdef JKB_PARITY_EN
  logic             q_par;
`endif

  modport master (
    output req0_valid, req0_op, req0_mask,
    output req1_valid, req1_op, req1_mask,
    input  req0_ready, req1_ready,
    input  q, qn, busy, grant, done
`ifdef JKB_PARITY_EN
    , input q_par
`endif
  );

  modport slave (
    input  req0_valid, req0_op, req0_mask,
    input  req1_valid, req1_op, req1_mask,
    output req0_ready, req1_ready,
    output q, qn, busy, grant, done
`ifdef JKB_PARITY_EN
    , output q_par
`endif
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - two-requester round-robin arbiter driving a bank of JK cells
// Optional registered parity output q_par enabled by JKB_PARITY_EN.
module jk_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  jk_bank_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic             rr_q;
  logic             grant_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             sel_d;
  logic             ready0_d;
  logic             ready1_d;
  logic             accept_d;
`ifdef JKB_PARITY_EN
  logic             q_par_q;
`endif

  // A lone valid requester wins outright; the pointer only breaks ties.
  always_comb begin
    sel_d = rr_q;
    if (bus.req0_valid && !bus.req1_valid) begin
      sel_d = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      sel_d = 1'b1;
    end
    ready0_d = (state_q == S_IDLE) && bus.req0_valid && !sel_d;
    ready1_d = (state_q == S_IDLE) && bus.req1_valid &&  sel_d;
    accept_d = ready0_d || ready1_d;
  end

  // JK next state per cell; unmasked cells see J=K=0 and hold.
  always_comb begin
    j_d = mask_q & {WIDTH{op_q[1]}};
    k_d = mask_q & {WIDTH{op_q[0]}};
    q_d = (j_d & ~q_q) | (~k_d & q_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= 2'b00;
      mask_q  <= '0;
      q_q     <= '0;
`ifdef JKB_PARITY_EN
      q_par_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            op_q    <= sel_d ? bus.req1_op   : bus.req0_op;
            mask_q  <= sel_d ? bus.req1_mask : bus.req0_mask;
            grant_q <= sel_d;
            rr_q    <= ~sel_d;
            busy_q  <= 1'b1;
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          q_q     <= q_d;
`ifdef JKB_PARITY_EN
          q_par_q <= ^q_d;
`endif
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is masked by reset directly so it is low for the whole reset window.
  assign bus.req0_ready = ready0_d && rst;
  assign bus.req1_ready = ready1_d && rst;
  assign bus.q          = q_q;
  assign bus.qn         = ~q_q;
  assign bus.busy       = busy_q;
  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
`ifdef JKB_PARITY_EN
  assign bus.q_par      = q_par_q;
`endif

endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, number of JK cells in the controlled bank.
REQ-002 clk  in  1  single clock for all state; bank updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req0_valid  in  1  requester 0 command valid.
REQ-005 req0_op  in  2  requester 0 operation code.
REQ-006 req0_mask  in  WIDTH  requester 0 bit-select mask.
REQ-007 req0_ready  out  1  requester 0 command accepted this cycle.
REQ-008 req1_valid / req1_op / req1_mask / req1_ready  same directions and widths as requester 0.
REQ-009 q  out  WIDTH  bank state.
REQ-010 qn  out  WIDTH  bitwise complement of q, at all times.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 grant  out  1  index of the requester last accepted.
REQ-013 done  out  1  one-cycle completion pulse.

Function
REQ-014 Op encoding shall be: 00 HOLD (J=0,K=0), 01 RESET (J=0,K=1), 10 SET (J=1,K=0), 11 TOGGLE (J=1,K=1).
REQ-015 Op shall apply only to bits with mask=1; unmasked bits shall see J=K=0 and hold.
REQ-016 FSM states shall be IDLE, APPLY, DONE; IDLE->APPLY on accept, APPLY->DONE and DONE->IDLE unconditionally.
REQ-017 Selection in IDLE: one valid -> that requester; both valid -> requester at round-robin pointer; none -> stay IDLE.
REQ-018 reqX_ready shall be high only in IDLE for the selected requester; it may depend combinationally on valid.
REQ-019 Accept = valid & ready at a rising edge; op, mask and grant shall be latched at that edge.
REQ-020 The round-robin pointer shall point to the other requester after each accept.
REQ-021 q shall update at the edge leaving APPLY, one cycle after the accept edge.
REQ-022 done shall be high for exactly the DONE cycle, then the next accept is possible in the following IDLE cycle.
REQ-023 Throughput shall be one command per 3 cycles; neither ready shall be high in APPLY or DONE.
REQ-024 Mask=0 or op HOLD shall still run a full transaction with done, leaving q unchanged.
REQ-025 Changes to valid, op or mask after accept shall not affect the transaction in flight.

Reset
REQ-026 While rst=0: q=0, qn=all ones, state IDLE, pointer=0, grant=0, busy=0, done=0, both ready=0.
REQ-027 Reset asserted in APPLY or DONE shall abort the transaction: no q update from it, no done pulse.
REQ-028 The first accept after rst deasserts shall be possible at the first rising edge with rst=1.

Configuration
REQ-029 Macro JKB_PARITY_EN defined: an output q_par (1 bit) shall equal XOR of q, registered together with q, reset 0.
REQ-030 Macro JKB_PARITY_EN undefined: q_par shall not exist; all other behaviour shall be identical.

Verification
REQ-031 rst=0 with both valid=1 -> q=8'h00, qn=8'hFF, ready both 0, done=0, busy=0.
REQ-032 req0 SET mask 8'h0F from q=8'h00 -> q=8'h0F one edge after accept; done high for one cycle, one cycle later; grant=0.
REQ-033 q=8'h0F, req1 TOGGLE mask 8'hFF -> q=8'hF0, qn=8'h0F; then RESET mask 8'h30 -> q=8'hC0.
REQ-034 Both valid held for 4 transactions -> grant sequence 0,1,0,1; accepts spaced 3 cycles apart.
REQ-035 Reset asserted during APPLY of SET 8'hFF -> q=8'h00, no done pulse; the next command is accepted normally.
REQ-036 With JKB_PARITY_EN: q goes 8'h00 -> 8'h07 -> 8'h03 -> q_par 0, 1, 0, changing with q.
